// File: rtl/packet_output_arbiter.sv
// packet_output_arbiter
//   Per-output-port switch allocator for a wormhole NoC router. Competing
//   input ports are arbitrated round-robin; the winner owns the output link
//   from its head flit until its tail flit (or a watchdog release), and its
//   flit stream is passed combinationally onto the output valid/ready channel.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   req        per-input request (head flit routed to this output)
//   data_in    packed flits, input i at [i*DATA_WIDTH +: DATA_WIDTH]
//   valid_in   per-input flit valid
//   ready_in   per-input accept (only the granted input can see ready)
//   data_out   flit to the output link
//   valid_out  output flit valid
//   ready_out  downstream accept
//   grant      one-hot owner of the output, 0 when idle
//   busy       high while a packet owns the output
//   overrun    sticky, set when the watchdog forces a release
//
// state  | meaning
// IDLE   | no owner; arbitrate among req, grant on the next edge
// LOCKED | output owned by grant; flits pass through until tail/watchdog
module packet_output_arbiter #(
    parameter int INPUTS     = 3,
    parameter int DATA_WIDTH = 32,
    parameter int TYPE_WIDTH = 2,
    parameter int MAX_FLITS  = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [INPUTS-1:0]            req,
    input  logic [INPUTS*DATA_WIDTH-1:0] data_in,
    input  logic [INPUTS-1:0]            valid_in,
    output logic [INPUTS-1:0]            ready_in,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         valid_out,
    input  logic                         ready_out,
    output logic [INPUTS-1:0]            grant,
    output logic                         busy,
    output logic                         overrun
);

    localparam int PW = $clog2(INPUTS);
    localparam int CW = $clog2(MAX_FLITS);
    localparam logic [TYPE_WIDTH-1:0] TYPE_TAIL = TYPE_WIDTH'(3);
    localparam logic [CW-1:0]         CNT_LAST  = CW'(MAX_FLITS - 1);
    localparam logic [PW-1:0]         PTR_INIT  = PW'(INPUTS - 1);

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_t;

    state_t            state_q, state_d;
    logic [INPUTS-1:0] grant_q, grant_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              overrun_q, overrun_d;

    logic [PW-1:0]     gidx;
    logic              xfer;
    logic              is_tail;
    logic              release_pkt;
    logic              found;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            ptr_q     <= PTR_INIT;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            overrun_q <= overrun_d;
        end
    end

    // Index of the current owner, used to move the round-robin pointer.
    always_comb begin
        gidx = '0;
        for (int i = 0; i < INPUTS; i++) begin
            if (grant_q[i]) begin
                gidx = PW'(i);
            end
        end
    end

    // Zero-cycle passthrough of the owner's channel. grant_q is zero in IDLE
    // (and while reset is held), so every output falls to 0 there.
    always_comb begin
        data_out  = '0;
        valid_out = 1'b0;
        ready_in  = '0;
        for (int i = 0; i < INPUTS; i++) begin
            if (grant_q[i]) begin
                data_out    = data_in[i*DATA_WIDTH +: DATA_WIDTH];
                valid_out   = valid_in[i];
                ready_in[i] = ready_out;
            end
        end
    end

    assign xfer        = (state_q == ST_LOCKED) && valid_out && ready_out;
    assign is_tail     = (data_out[DATA_WIDTH-1 -: TYPE_WIDTH] == TYPE_TAIL);
    assign release_pkt = xfer && (is_tail || (cnt_q == CNT_LAST));

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        overrun_d = overrun_q;
        found     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Search from pointer+1 upward, wrapping; the last owner
                // is therefore considered last.
                for (int k = 1; k <= INPUTS; k++) begin
                    for (int i = 0; i < INPUTS; i++) begin
                        if (!found && req[i] && (i == (int'(ptr_q) + k) % INPUTS)) begin
                            found      = 1'b1;
                            grant_d    = '0;
                            grant_d[i] = 1'b1;
                        end
                    end
                end
                if (found) begin
                    state_d = ST_LOCKED;
                    cnt_d   = '0;
                end
            end
            ST_LOCKED: begin
                if (xfer) begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (release_pkt) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    ptr_d   = gidx;
                    if (!is_tail) begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    assign grant   = grant_q;
    assign busy    = (state_q == ST_LOCKED);
    assign overrun = overrun_q;

endmodule

// File: tb/tb_packet_output_arbiter.sv
module tb_packet_output_arbiter;

    localparam int N  = 3;
    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic [N-1:0]  req;
    logic [N-1:0]  valid_in;
    logic [N*DW-1:0] data_in;
    logic          ready_out;

    logic [N-1:0]  ready_in_m, grant_m, ready_in_w, grant_w;
    logic [DW-1:0] data_out_m, data_out_w;
    logic          valid_out_m, busy_m, overrun_m;
    logic          valid_out_w, busy_w, overrun_w;

    logic          use_wd;
    logic [N-1:0]  req_en;
    logic [N-1:0]  sel_ready;
    logic [N-1:0]  sel_grant;
    logic [DW-1:0] sel_data;
    logic          sel_valid;

    logic [DW-1:0] flits [N][64];
    int            len [N] = '{0, 0, 0};
    int            pos [N] = '{0, 0, 0};
    int            cyc = 0;

    logic [DW-1:0] log_d [$];
    logic [N-1:0]  log_g [$];
    int            log_c [$];

    int checks = 0;
    int errors = 0;

    packet_output_arbiter #(.INPUTS(N), .DATA_WIDTH(DW), .TYPE_WIDTH(2), .MAX_FLITS(64)) dut (
        .clk(clk), .rst(rst), .req(req), .data_in(data_in), .valid_in(valid_in),
        .ready_in(ready_in_m), .data_out(data_out_m), .valid_out(valid_out_m),
        .ready_out(ready_out), .grant(grant_m), .busy(busy_m), .overrun(overrun_m)
    );

    packet_output_arbiter #(.INPUTS(N), .DATA_WIDTH(DW), .TYPE_WIDTH(2), .MAX_FLITS(4)) dut_wd (
        .clk(clk), .rst(rst), .req(req), .data_in(data_in), .valid_in(valid_in),
        .ready_in(ready_in_w), .data_out(data_out_w), .valid_out(valid_out_w),
        .ready_out(ready_out), .grant(grant_w), .busy(busy_w), .overrun(overrun_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign sel_ready = use_wd ? ready_in_w  : ready_in_m;
    assign sel_grant = use_wd ? grant_w     : grant_m;
    assign sel_data  = use_wd ? data_out_w  : data_out_m;
    assign sel_valid = use_wd ? valid_out_w : valid_out_m;

    // Upstream FIFOs: each input presents flits[i][pos[i]] until accepted.
    always_comb begin
        valid_in = '0;
        req      = '0;
        data_in  = '0;
        for (int i = 0; i < N; i++) begin
            valid_in[i] = (pos[i] < len[i]);
            if (valid_in[i]) data_in[i*DW +: DW] = flits[i][pos[i][5:0]];
            req[i] = req_en[i] & valid_in[i];
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < N; i++) begin
            if (sel_ready[i] && valid_in[i]) pos[i] <= pos[i] + 1;
        end
        if (sel_valid && ready_out) begin
            log_d.push_back(sel_data);
            log_g.push_back(sel_grant);
            log_c.push_back(cyc);
        end
    end

    task automatic load(input int i, input logic [DW-1:0] f);
        flits[i][len[i][5:0]] = f;
        len[i] = len[i] + 1;
    endtask

    task automatic do_reset();
        req_en = '0;
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({grant_m, busy_m, overrun_m, valid_out_m, ready_in_m} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: got grant=%b busy=%b ovr=%b vout=%b rdy=%b required all 0",
                     grant_m, busy_m, overrun_m, valid_out_m, ready_in_m);
        end
        checks++;
        if (data_out_m !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h required 0", data_out_m);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        logic [DW-1:0] exp_d [6] = '{32'h40000005, 32'h80000012, 32'h80000013,
                                     32'h80000014, 32'h80000015, 32'hC0000016};
        int base = log_d.size();
        for (int k = 0; k < 6; k++) load(0, exp_d[k]);
        req_en = 3'b001;
        #1;
        checks++;
        if (grant_m !== 3'b000 || valid_out_m !== 1'b0) begin
            errors++;
            $display("FAIL single_pre_grant: got grant=%b vout=%b required 000/0", grant_m, valid_out_m);
        end
        @(posedge clk); #1;
        checks++;
        if (grant_m !== 3'b001 || busy_m !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: got grant=%b busy=%b required 001/1", grant_m, busy_m);
        end
        checks++;
        if (data_out_m !== 32'h40000005 || valid_out_m !== 1'b1 || ready_in_m !== 3'b001) begin
            errors++;
            $display("FAIL single_head: got data=%h vout=%b rdy=%b required 40000005/1/001",
                     data_out_m, valid_out_m, ready_in_m);
        end
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (grant_m !== 3'b000 || busy_m !== 1'b0) begin
            errors++;
            $display("FAIL single_release: got grant=%b busy=%b required 000/0", grant_m, busy_m);
        end
        checks++;
        if (log_d.size() != base + 6) begin
            errors++;
            $display("FAIL single_count: got %0d transfers required 6", log_d.size() - base);
        end else begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (log_d[base+k] !== exp_d[k] || log_c[base+k] != log_c[base] + k) begin
                    errors++;
                    $display("FAIL single_flit%0d: got %h at cycle +%0d required %h at +%0d",
                             k, log_d[base+k], log_c[base+k] - log_c[base], exp_d[k], k);
                end
            end
        end
        req_en = '0;
    endtask

    task automatic test_two_req();
        logic [DW-1:0] exp_d [12] = '{32'h40000001, 32'h80000011, 32'h80000012, 32'h80000013,
                                      32'h80000014, 32'hC0000015, 32'h40000004, 32'h80000022,
                                      32'h80000023, 32'h80000024, 32'h80000025, 32'hC0000026};
        int base;
        int k;
        do_reset();
        base = log_d.size();
        for (int j = 0; j < 6; j++) load(0, exp_d[j]);
        for (int j = 6; j < 12; j++) load(1, exp_d[j]);
        req_en = 3'b011;
        @(posedge clk); #1;
        checks++;
        if (grant_m !== 3'b001 || ready_in_m !== 3'b001) begin
            errors++;
            $display("FAIL two_first_owner: got grant=%b rdy=%b required 001/001", grant_m, ready_in_m);
        end
        k = 0;
        while (log_d.size() < base + 12 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        checks++;
        if (log_d.size() != base + 12) begin
            errors++;
            $display("FAIL two_count: got %0d transfers required 12", log_d.size() - base);
        end else begin
            for (int j = 0; j < 12; j++) begin
                checks++;
                if (log_d[base+j] !== exp_d[j] || log_g[base+j] !== (j < 6 ? 3'b001 : 3'b010)) begin
                    errors++;
                    $display("FAIL two_flit%0d: got %h grant=%b required %h grant=%b",
                             j, log_d[base+j], log_g[base+j], exp_d[j], (j < 6 ? 3'b001 : 3'b010));
                end
            end
            checks++;
            if (log_c[base+6] - log_c[base+5] != 2) begin
                errors++;
                $display("FAIL two_gap: got %0d cycles tail-to-head required 2",
                         log_c[base+6] - log_c[base+5]);
            end
        end
        req_en = '0;
    endtask

    task automatic test_rr();
        logic [DW-1:0] exp_d [8] = '{32'h40000A00, 32'hC0000A01, 32'h40000B00, 32'hC0000B01,
                                     32'h40000C00, 32'hC0000C01, 32'h40000A10, 32'hC0000A11};
        logic [N-1:0]  exp_g [8] = '{3'b001, 3'b001, 3'b010, 3'b010,
                                     3'b100, 3'b100, 3'b001, 3'b001};
        int base;
        int k;
        do_reset();
        base = log_d.size();
        load(0, exp_d[0]); load(0, exp_d[1]); load(0, exp_d[6]); load(0, exp_d[7]);
        load(1, exp_d[2]); load(1, exp_d[3]);
        load(2, exp_d[4]); load(2, exp_d[5]);
        req_en = 3'b111;
        k = 0;
        while (log_d.size() < base + 8 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        checks++;
        if (log_d.size() != base + 8) begin
            errors++;
            $display("FAIL rr_count: got %0d transfers required 8", log_d.size() - base);
        end else begin
            for (int j = 0; j < 8; j++) begin
                checks++;
                if (log_d[base+j] !== exp_d[j] || log_g[base+j] !== exp_g[j]) begin
                    errors++;
                    $display("FAIL rr_flit%0d: got %h grant=%b required %h grant=%b",
                             j, log_d[base+j], log_g[base+j], exp_d[j], exp_g[j]);
                end
            end
            checks++;
            if (log_c[base+2] - log_c[base+1] != 2) begin
                errors++;
                $display("FAIL rr_gap: got %0d cycles required 2", log_c[base+2] - log_c[base+1]);
            end
        end
        req_en = '0;
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] exp_d [4] = '{32'h40000D00, 32'h80000D01, 32'h80000D02, 32'hC0000D03};
        logic          pat [6]   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        int base;
        int idx = 0;
        do_reset();
        base = log_d.size();
        for (int j = 0; j < 4; j++) load(1, exp_d[j]);
        req_en = 3'b010;
        @(posedge clk); #1;
        for (int k = 0; k < 6; k++) begin
            ready_out = pat[k];
            #1;
            checks++;
            if (grant_m !== 3'b010 || ready_in_m !== (pat[k] ? 3'b010 : 3'b000)) begin
                errors++;
                $display("FAIL bp_cycle%0d: got grant=%b rdy=%b required 010/%b",
                         k, grant_m, ready_in_m, (pat[k] ? 3'b010 : 3'b000));
            end
            checks++;
            if (data_out_m !== exp_d[idx] || valid_out_m !== 1'b1) begin
                errors++;
                $display("FAIL bp_data%0d: got %h vout=%b required %h/1", k, data_out_m, valid_out_m, exp_d[idx]);
            end
            @(posedge clk);
            if (pat[k]) idx++;
            #1;
        end
        ready_out = 1'b1;
        checks++;
        if (grant_m !== 3'b000) begin
            errors++;
            $display("FAIL bp_release: got grant=%b required 000", grant_m);
        end
        checks++;
        if (log_d.size() != base + 4) begin
            errors++;
            $display("FAIL bp_count: got %0d transfers required 4", log_d.size() - base);
        end else begin
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (log_d[base+j] !== exp_d[j]) begin
                    errors++;
                    $display("FAIL bp_flit%0d: got %h required %h", j, log_d[base+j], exp_d[j]);
                end
            end
        end
        req_en = '0;
    endtask

    task automatic test_watchdog();
        logic [DW-1:0] exp_d [6] = '{32'h40000E00, 32'h80000E01, 32'h80000E02,
                                     32'h80000E03, 32'h80000E04, 32'hC0000E05};
        int base;
        int k;
        use_wd = 1'b1;
        do_reset();
        base = log_d.size();
        for (int j = 0; j < 6; j++) load(0, exp_d[j]);
        req_en = 3'b001;
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (grant_w !== 3'b001 || overrun_w !== 1'b0) begin
            errors++;
            $display("FAIL wd_before: got grant=%b ovr=%b required 001/0", grant_w, overrun_w);
        end
        @(posedge clk); #1;
        checks++;
        if (grant_w !== 3'b000 || busy_w !== 1'b0 || overrun_w !== 1'b1) begin
            errors++;
            $display("FAIL wd_release: got grant=%b busy=%b ovr=%b required 000/0/1", grant_w, busy_w, overrun_w);
        end
        k = 0;
        while (log_d.size() < base + 6 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (log_d.size() != base + 6) begin
            errors++;
            $display("FAIL wd_count: got %0d transfers required 6", log_d.size() - base);
        end else begin
            for (int j = 0; j < 6; j++) begin
                checks++;
                if (log_d[base+j] !== exp_d[j]) begin
                    errors++;
                    $display("FAIL wd_flit%0d: got %h required %h", j, log_d[base+j], exp_d[j]);
                end
            end
            checks++;
            if (log_c[base+4] - log_c[base+3] != 2) begin
                errors++;
                $display("FAIL wd_gap: got %0d cycles required 2", log_c[base+4] - log_c[base+3]);
            end
        end
        checks++;
        if (overrun_w !== 1'b1) begin
            errors++;
            $display("FAIL wd_sticky: got ovr=%b required 1", overrun_w);
        end
        do_reset();
        checks++;
        if (overrun_w !== 1'b0) begin
            errors++;
            $display("FAIL wd_clear: got ovr=%b required 0", overrun_w);
        end
        use_wd = 1'b0;
    endtask

    task automatic test_async_reset();
        int base;
        do_reset();
        for (int j = 0; j < 5; j++) load(1, 32'h80000F00 + DW'(j));
        flits[1][len[1][5:0] - 5] = 32'h40000F00;
        load(1, 32'hC0000F05);
        req_en = 3'b010;
        @(posedge clk); #1;
        checks++;
        if (grant_m !== 3'b010) begin
            errors++;
            $display("FAIL ar_grant: got %b required 010", grant_m);
        end
        repeat (2) @(posedge clk);
        #1;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({grant_m, valid_out_m, ready_in_m, busy_m} !== '0 || data_out_m !== '0) begin
            errors++;
            $display("FAIL ar_immediate: got grant=%b vout=%b rdy=%b busy=%b data=%h required all 0",
                     grant_m, valid_out_m, ready_in_m, busy_m, data_out_m);
        end
        req_en = '0;
        #1 rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (grant_m !== 3'b000) begin
            errors++;
            $display("FAIL ar_idle: got grant=%b required 000", grant_m);
        end
        base = log_d.size();
        load(2, 32'h40000C10);
        load(2, 32'hC0000C11);
        req_en = 3'b100;
        @(posedge clk); #1;
        checks++;
        if (grant_m !== 3'b100) begin
            errors++;
            $display("FAIL ar_regrant: got %b required 100", grant_m);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (log_d.size() != base + 2 || grant_m !== 3'b000) begin
            errors++;
            $display("FAIL ar_packet: got %0d transfers grant=%b required 2/000", log_d.size() - base, grant_m);
        end else begin
            checks++;
            if (log_d[base] !== 32'h40000C10 || log_d[base+1] !== 32'hC0000C11) begin
                errors++;
                $display("FAIL ar_data: got %h %h required 40000c10 c0000c11", log_d[base], log_d[base+1]);
            end
        end
        req_en = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        req_en    = '0;
        ready_out = 1'b1;
        use_wd    = 1'b0;
        test_reset();
        test_single();
        test_two_req();
        test_rr();
        test_backpressure();
        test_watchdog();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
